// File: rtl/pcpi_dispatch_pkg.sv
// Shared M-extension definitions: opcodes, funct encodings and the dispatch FSM states.
package pcpi_dispatch_pkg;

  localparam logic [6:0] OPCODE        = 7'b0110011;
  localparam logic [6:0] OPCODE_CUSTOM = 7'b0001011;
  localparam logic [6:0] FUNC7         = 7'b0000001;

  localparam logic [2:0] ADDMOD = 3'd0;
  localparam logic [2:0] SUBMOD = 3'd1;
  localparam logic [2:0] MULQ   = 3'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    COOL  = 3'd4
  } dispatch_state_t;

  function automatic logic [1:0] unit_onehot(input logic sel);
    unit_onehot = sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/pcpi_decode.sv
// Combinational instruction decode: decides whether the dispatcher claims an
// instruction and which unit (0 = M unit, 1 = custom unit) executes it.
module pcpi_decode (
  input  logic [31:0] insn,
  output logic        claim,
  output logic        sel
);
  import pcpi_dispatch_pkg::*;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_bits;

  assign opcode      = insn[6:0];
  assign funct3      = insn[14:12];
  assign funct7      = insn[31:25];
  assign unused_bits = ^{insn[24:15], insn[11:7]};

  always_comb begin
    claim = 1'b0;
    sel   = 1'b0;
    if (opcode == OPCODE && funct7 == FUNC7) begin
      claim = 1'b1;
      sel   = 1'b0;
    end else if (opcode == OPCODE_CUSTOM &&
                 (funct3 == ADDMOD || funct3 == SUBMOD || funct3 == MULQ)) begin
      claim = 1'b1;
      sel   = 1'b1;
    end
  end

endmodule

// File: rtl/pcpi_dispatch.sv
// PCPI dispatcher: claims M-extension and custom instructions from the core,
// forwards them to one of two execution units and returns the result with a timeout guard.
module pcpi_dispatch #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic [1:0]  u_valid,
  output logic [31:0] u_insn,
  output logic [31:0] u_rs1,
  output logic [31:0] u_rs2,
  input  logic [1:0]  u_ready,
  input  logic [1:0]  u_wr,
  input  logic [31:0] u_rd0,
  input  logic [31:0] u_rd1,
  output logic        err_timeout,
  input  logic        err_clear
);
  import pcpi_dispatch_pkg::*;

  localparam logic [7:0] TERM = 8'(TIMEOUT_CYCLES);

  dispatch_state_t state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic        sel_q, sel_n;
  logic        dec_claim, dec_sel;
  logic        capture;
  logic        wait_n;
  logic [1:0]  u_valid_n;
  logic        ready_n;
  logic        wr_n;
  logic [31:0] rd_n;
  logic        err_n;

  pcpi_decode u_decode (
    .insn  (pcpi_insn),
    .claim (dec_claim),
    .sel   (dec_sel)
  );

  // All outputs are registered from the next state so they line up with the state register.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = sel_q;
    capture = 1'b0;
    rd_n    = '0;
    wr_n    = 1'b0;
    err_n   = err_timeout & ~err_clear;
    unique case (state)
      IDLE: begin
        if (pcpi_valid && dec_claim) begin
          capture = 1'b1;
          sel_n   = dec_sel;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (!pcpi_valid) begin
          state_n = IDLE;
        end else begin
          cnt_n   = '0;
          state_n = WAIT;
        end
      end
      WAIT: begin
        // Core abort beats completion; completion beats the terminal count.
        if (!pcpi_valid) begin
          state_n = IDLE;
        end else if (u_ready[sel_q]) begin
          state_n = RESP;
          rd_n    = sel_q ? u_rd1 : u_rd0;
          wr_n    = u_wr[sel_q];
        end else if (cnt + 8'd1 == TERM) begin
          state_n = RESP;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      RESP:    state_n = COOL;
      COOL:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    wait_n    = (state_n == ISSUE) || (state_n == WAIT);
    u_valid_n = wait_n ? unit_onehot(sel_n) : 2'b00;
    ready_n   = (state_n == RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      sel_q       <= 1'b0;
      pcpi_wait   <= 1'b0;
      u_valid     <= 2'b00;
      pcpi_ready  <= 1'b0;
      pcpi_wr     <= 1'b0;
      pcpi_rd     <= '0;
      err_timeout <= 1'b0;
      u_insn      <= '0;
      u_rs1       <= '0;
      u_rs2       <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sel_q       <= sel_n;
      pcpi_wait   <= wait_n;
      u_valid     <= u_valid_n;
      pcpi_ready  <= ready_n;
      pcpi_wr     <= wr_n;
      pcpi_rd     <= rd_n;
      err_timeout <= err_n;
      if (capture) begin
        u_insn <= pcpi_insn;
        u_rs1  <= pcpi_rs1;
        u_rs2  <= pcpi_rs2;
      end
    end
  end

endmodule

// File: tb/tb_pcpi_dispatch.sv
// Bench for pcpi_dispatch: two instances (timeout 64 and 8) share stimulus and are
// compared against a cycle-count model of the dispatch protocol.
module tb_pcpi_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic        err_clear;
  logic [1:0]  valid;
  logic [31:0] insn, rs1, rs2;
  logic [1:0]  u_ready, u_wr;
  logic [31:0] u_rd0, u_rd1;

  logic        wr_s    [2];
  logic [31:0] rd_s    [2];
  logic        wait_s  [2];
  logic        ready_s [2];
  logic [1:0]  uv_s    [2];
  logic [31:0] uins_s  [2];
  logic [31:0] urs1_s  [2];
  logic [31:0] urs2_s  [2];
  logic        err_s   [2];

  localparam int T_INST [2] = '{64, 8};

  always #5 clk = ~clk;

  pcpi_dispatch dut_a (
    .clk(clk), .reset(reset), .pcpi_valid(valid[0]), .pcpi_insn(insn),
    .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(wr_s[0]), .pcpi_rd(rd_s[0]),
    .pcpi_wait(wait_s[0]), .pcpi_ready(ready_s[0]), .u_valid(uv_s[0]),
    .u_insn(uins_s[0]), .u_rs1(urs1_s[0]), .u_rs2(urs2_s[0]),
    .u_ready(u_ready), .u_wr(u_wr), .u_rd0(u_rd0), .u_rd1(u_rd1),
    .err_timeout(err_s[0]), .err_clear(err_clear)
  );

  pcpi_dispatch #(.TIMEOUT_CYCLES(8)) dut_b (
    .clk(clk), .reset(reset), .pcpi_valid(valid[1]), .pcpi_insn(insn),
    .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(wr_s[1]), .pcpi_rd(rd_s[1]),
    .pcpi_wait(wait_s[1]), .pcpi_ready(ready_s[1]), .u_valid(uv_s[1]),
    .u_insn(uins_s[1]), .u_rs1(urs1_s[1]), .u_rs2(urs2_s[1]),
    .u_ready(u_ready), .u_wr(u_wr), .u_rd0(u_rd0), .u_rd1(u_rd1),
    .err_timeout(err_s[1]), .err_clear(err_clear)
  );

  typedef struct {
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    int          k;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        wr0;
    logic        wr1;
    logic        clr;
    logic [1:0]  exp_uv;
    logic [31:0] exp_rd;
    logic        exp_wr;
  } vec_t;

  vec_t vecs [10];

  int n_checks = 0;
  int n_pass   = 0;

  int          rdy_edge [2];
  int          rdy_cnt  [2];
  int          uv_cnt   [2];
  int          wait_cnt [2];
  int          leak     [2];
  int          insn_bad [2];
  logic [31:0] rd_at    [2];
  logic        wr_at    [2];
  logic        err_at   [2];
  logic        err_end  [2];
  logic [1:0]  uv_or    [2];
  logic        exp_err  [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic void model_decode(input logic [31:0] w, output logic claim, output logic sel);
    claim = 1'b0;
    sel   = 1'b0;
    if (w[6:0] == 7'h33 && w[31:25] == 7'h01) begin
      claim = 1'b1;
    end else if (w[6:0] == 7'h0B && w[14:12] <= 3'd2) begin
      claim = 1'b1;
      sel   = 1'b1;
    end
  endfunction

  // One core request; the selected unit answers in WAIT cycle k.
  task automatic run_txn(input logic [31:0] t_insn, t_rs1, t_rs2, input int k,
                         input logic [31:0] t_rd0, t_rd1, input logic t_wr0, t_wr1, t_clr);
    logic claim, sel;
    int lim;
    model_decode(t_insn, claim, sel);
    lim = k + 6;
    for (int i = 0; i < 2; i++) begin
      rdy_edge[i] = -1; rdy_cnt[i] = 0; uv_cnt[i] = 0; wait_cnt[i] = 0;
      leak[i] = 0; insn_bad[i] = 0; rd_at[i] = '0; wr_at[i] = 1'b0;
      err_at[i] = 1'b0; err_end[i] = 1'b0; uv_or[i] = 2'b00;
    end
    @(negedge clk);
    insn = t_insn; rs1 = t_rs1; rs2 = t_rs2;
    u_rd0 = t_rd0; u_rd1 = t_rd1; u_wr = {t_wr1, t_wr0};
    err_clear = t_clr; valid = 2'b11; u_ready = 2'b00;
    for (int e = 0; e <= lim; e++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (ready_s[i]) begin
          if (rdy_cnt[i] == 0) begin
            rdy_edge[i] = e; rd_at[i] = rd_s[i]; wr_at[i] = wr_s[i]; err_at[i] = err_s[i];
          end
          rdy_cnt[i]++;
          valid[i] = 1'b0;
        end else if (rd_s[i] != 32'd0 || wr_s[i]) begin
          leak[i]++;
        end
        if (uv_s[i] != 2'b00) uv_cnt[i]++;
        uv_or[i] = uv_or[i] | uv_s[i];
        if (wait_s[i]) begin
          wait_cnt[i]++;
          if (uins_s[i] !== t_insn || urs1_s[i] !== t_rs1 || urs2_s[i] !== t_rs2) insn_bad[i]++;
        end
        err_end[i] = err_s[i];
      end
      u_ready = 2'b00;
      if (e == k) u_ready[sel] = 1'b1;
      u_ready[~sel] = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    valid = 2'b00; u_ready = 2'b00; err_clear = 1'b0;
  endtask

  task automatic check_txn(input string tag, input int i, input logic [31:0] t_insn, input int k,
                           input logic [31:0] t_rd0, t_rd1, input logic t_wr0, t_wr1, t_clr);
    logic claim, sel, timed;
    int t, m;
    string p;
    model_decode(t_insn, claim, sel);
    t = T_INST[i];
    m = (k < t) ? k : t;
    timed = claim && (k > t);
    p = $sformatf("%s inst%0d", tag, i);
    if (claim) begin
      chk({p, " ready_edge"}, 32'(rdy_edge[i]), 32'(1 + m));
      chk({p, " ready_pulses"}, 32'(rdy_cnt[i]), 32'd1);
      chk({p, " rd"}, rd_at[i], timed ? 32'd0 : (sel ? t_rd1 : t_rd0));
      chk({p, " wr"}, 32'(wr_at[i]), timed ? 32'd0 : 32'(sel ? t_wr1 : t_wr0));
      chk({p, " u_valid_cycles"}, 32'(uv_cnt[i]), 32'(m + 1));
      chk({p, " wait_cycles"}, 32'(wait_cnt[i]), 32'(m + 1));
      chk({p, " err_at_ready"}, 32'(err_at[i]), 32'(timed | (exp_err[i] & ~t_clr)));
      chk({p, " u_insn_hold"}, 32'(insn_bad[i]), 32'd0);
    end else begin
      chk({p, " ready_pulses"}, 32'(rdy_cnt[i]), 32'd0);
      chk({p, " u_valid_cycles"}, 32'(uv_cnt[i]), 32'd0);
      chk({p, " wait_cycles"}, 32'(wait_cnt[i]), 32'd0);
    end
    chk({p, " u_valid_bits"}, 32'(uv_or[i]), claim ? (sel ? 32'd2 : 32'd1) : 32'd0);
    chk({p, " rd_wr_outside_resp"}, 32'(leak[i]), 32'd0);
    exp_err[i] = t_clr ? 1'b0 : (exp_err[i] | timed);
    chk({p, " err_end"}, 32'(err_end[i]), 32'(exp_err[i]));
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s inst%0d outputs", tag, i),
          {16'd0, 4'd0, uv_s[i], wait_s[i], ready_s[i], wr_s[i], err_s[i], 4'd0}, 32'd0);
      chk($sformatf("%s inst%0d rd", tag, i), rd_s[i], 32'd0);
      chk($sformatf("%s inst%0d latched", tag, i), uins_s[i] | urs1_s[i] | urs2_s[i], 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pulses;
    reset = 1'b1; err_clear = 1'b0; valid = 2'b00; insn = '0; rs1 = '0; rs2 = '0;
    u_ready = 2'b00; u_wr = 2'b00; u_rd0 = '0; u_rd1 = '0;
    exp_err[0] = 1'b0; exp_err[1] = 1'b0;

    vecs[0] = '{32'h02B50533, 32'd7, 32'd6, 10, 32'd42, 32'h55, 1'b1, 1'b0, 1'b0, 2'b01, 32'd42, 1'b1};
    vecs[1] = '{32'h00B5050B, 32'd1, 32'd2, 3, 32'hDEADBEEF, 32'h123, 1'b0, 1'b1, 1'b0, 2'b10, 32'h123, 1'b1};
    vecs[2] = '{32'h00000013, 32'd3, 32'd4, 19, 32'd1, 32'd2, 1'b1, 1'b1, 1'b0, 2'b00, 32'd0, 1'b0};
    vecs[3] = '{32'h02B54533, 32'd100, 32'd9, 1, 32'h1234, 32'h9, 1'b1, 1'b0, 1'b0, 2'b01, 32'h1234, 1'b1};
    vecs[4] = '{32'h00B5150B, 32'd5, 32'd5, 5, 32'h77, 32'hABCD, 1'b1, 1'b0, 1'b0, 2'b10, 32'hABCD, 1'b0};
    vecs[5] = '{32'h00B5350B, 32'd5, 32'd5, 4, 32'h77, 32'h88, 1'b1, 1'b1, 1'b0, 2'b00, 32'd0, 1'b0};
    vecs[6] = '{32'h00B50533, 32'd5, 32'd5, 4, 32'h77, 32'h88, 1'b1, 1'b1, 1'b0, 2'b00, 32'd0, 1'b0};
    vecs[7] = '{32'h00B5250B, 32'd2, 32'd3, 8, 32'hDEAD, 32'd5, 1'b0, 1'b1, 1'b0, 2'b10, 32'd5, 1'b1};
    vecs[8] = '{32'h02B50533, 32'd3, 32'd3, 20, 32'd9, 32'd8, 1'b1, 1'b1, 1'b0, 2'b01, 32'd9, 1'b1};
    vecs[9] = '{32'h00B5250B, 32'd4, 32'd4, 12, 32'd1, 32'h4444, 1'b1, 1'b1, 1'b1, 2'b10, 32'h4444, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int r = 0; r < 10; r++) begin
      string tag;
      tag = $sformatf("row%0d", r);
      run_txn(vecs[r].insn, vecs[r].rs1, vecs[r].rs2, vecs[r].k, vecs[r].rd0, vecs[r].rd1,
              vecs[r].wr0, vecs[r].wr1, vecs[r].clr);
      chk({tag, " table u_valid"}, 32'(uv_or[0]), 32'(vecs[r].exp_uv));
      chk({tag, " table rd"}, rd_at[0], vecs[r].exp_rd);
      chk({tag, " table wr"}, 32'(wr_at[0]), 32'(vecs[r].exp_wr));
      for (int i = 0; i < 2; i++)
        check_txn(tag, i, vecs[r].insn, vecs[r].k, vecs[r].rd0, vecs[r].rd1,
                  vecs[r].wr0, vecs[r].wr1, vecs[r].clr);
    end

    // Timeout flag holds across idle cycles, then a single err_clear drops it.
    run_txn(32'h02B50533, 32'd1, 32'd1, 20, 32'd3, 32'd4, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) check_txn("timeout", i, 32'h02B50533, 20, 32'd3, 32'd4, 1'b1, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("err hold", 32'(err_s[1]), 32'd1);
    @(negedge clk);
    err_clear = 1'b1;
    @(posedge clk);
    #1;
    chk("err clear", 32'(err_s[1]), 32'd0);
    exp_err[1] = 1'b0;
    @(negedge clk);
    err_clear = 1'b0;

    // Core abort: instance b drops valid in ISSUE, instance a in WAIT cycle 2.
    pulses = 0;
    insn = 32'h02B50533; rs1 = 32'd7; rs2 = 32'd6; valid = 2'b11; u_ready = 2'b00;
    for (int e = 0; e <= 10; e++) begin
      @(posedge clk);
      #1;
      pulses += int'(ready_s[0]) + int'(ready_s[1]);
      if (e == 0) valid[1] = 1'b0;
      if (e == 1) chk("abort issue u_valid/wait", {30'd0, uv_s[1] != 2'b00, wait_s[1]}, 32'd0);
      if (e == 2) valid[0] = 1'b0;
      if (e == 3) chk("abort wait u_valid/wait", {30'd0, uv_s[0] != 2'b00, wait_s[0]}, 32'd0);
      u_ready = (e == 4) ? 2'b11 : 2'b00;
    end
    chk("abort no ready", 32'(pulses), 32'd0);

    // Reset in WAIT cycle 3, unit answers two cycles after the reset.
    pulses = 0;
    @(negedge clk);
    valid = 2'b11;
    for (int e = 0; e <= 9; e++) begin
      @(posedge clk);
      #1;
      pulses += int'(ready_s[0]) + int'(ready_s[1]);
      if (e == 3) begin reset = 1'b1; valid = 2'b00; end
      if (e == 4) begin reset = 1'b0; check_all_zero("mid reset"); end
      u_ready = (e == 5) ? 2'b11 : 2'b00;
    end
    chk("reset no ready", 32'(pulses), 32'd0);
    exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    run_txn(32'h02B50533, 32'd7, 32'd6, 3, 32'd42, 32'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) check_txn("post reset", i, 32'h02B50533, 3, 32'd42, 32'd0, 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      logic [31:0] w, a0, a1;
      logic b0, b1, c;
      int kk;
      w = $urandom;
      case ($urandom_range(0, 3))
        0: begin w[6:0] = 7'h33; w[31:25] = 7'h01; end
        1: w[6:0] = 7'h0B;
        2: w[6:0] = 7'h33;
        default: ;
      endcase
      kk = $urandom_range(1, 14);
      a0 = $urandom; a1 = $urandom;
      b0 = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 4) == 0);
      run_txn(w, $urandom, $urandom, kk, a0, a1, b0, b1, c);
      for (int i = 0; i < 2; i++) check_txn($sformatf("rand%0d", n), i, w, kk, a0, a1, b0, b1, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
